// File: rtl/aer_tx_arbiter_if.sv
// AER transmitter bundle: firing inputs, 4-phase req/ack/addr link, and status outputs.
interface aer_tx_if #(
    parameter int NCH = 4,
    parameter int AW  = 2
) ();
    logic [NCH-1:0] fe;
    logic           aer_req;
    logic [AW-1:0]  aer_addr;
    logic           aer_ack;
    logic [NCH-1:0] evt_lost;
    logic           busy;
    logic           timeout_err;

    modport master (
        input  fe, aer_ack,
        output aer_req, aer_addr, evt_lost, busy, timeout_err
    );

    modport slave (
        output fe, aer_ack,
        input  aer_req, aer_addr, evt_lost, busy, timeout_err
    );
endinterface

// File: rtl/aer_tx_arbiter.sv
// Round-robin AER event transmitter with per-channel pending buffer and 4-phase req/ack.
// Optional handshake timeout enabled by defining AER_TX_TIMEOUT_EN.
//   state | meaning
//   IDLE  | no handshake in flight; launches when a channel is pending and ack is low
//   REQ   | aer_req high, waiting for ack to rise
//   ACKLO | aer_req low, waiting for ack to fall
module aer_tx_arbiter #(
    parameter int NCH     = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     reset,
    aer_tx_if.master aer
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (NCH < 2 || NCH > 64 || AW < PW || TIMEOUT < 1) begin : g_bad_param
            $error("aer_tx_arbiter: illegal NCH/AW/TIMEOUT combination");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKLO} state_t;

    state_t         r_state;
    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_lost;
    logic [PW-1:0]  r_rr;
    logic           r_req;
    logic [AW-1:0]  r_addr;

    logic [PW:0]    w_pick;
    logic [PW-1:0]  w_grant;
    logic           w_launch;
    logic [NCH-1:0] w_clr;

    // MSB flags a hit; lower bits are the first pending index at or after rr.
    function automatic logic [PW:0] pick_first(input logic [NCH-1:0] pend,
                                               input logic [PW-1:0]  rr);
        logic [PW:0]   res;
        logic [PW-1:0] ix;
        int            idx;
        res = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr) + k;
            if (idx >= NCH) idx = idx - NCH;
            ix = PW'(idx);
            if (!res[PW] && pend[ix]) res = {1'b1, ix};
        end
        return res;
    endfunction

    assign w_pick   = pick_first(r_pend, r_rr);
    assign w_grant  = w_pick[PW-1:0];
    assign w_launch = (r_state == S_IDLE) && w_pick[PW] && !aer.aer_ack;
    assign w_clr    = w_launch ? ({{(NCH-1){1'b0}}, 1'b1} << w_grant) : '0;

`ifdef AER_TX_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] r_cnt;
    logic          r_terr;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_lost  <= '0;
            r_rr    <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
`ifdef AER_TX_TIMEOUT_EN
            r_cnt   <= '0;
            r_terr  <= 1'b0;
`endif
        end else begin
            // A new firing on the grant edge re-arms the channel rather than being lost.
            r_pend <= (r_pend & ~w_clr) | aer.fe;
            r_lost <= aer.fe & r_pend & ~w_clr;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= AW'(w_grant);
                        r_rr    <= (w_grant == PW'(NCH - 1)) ? '0 : w_grant + 1'b1;
`ifdef AER_TX_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (aer.aer_ack) begin
                        r_state <= S_ACKLO;
                        r_req   <= 1'b0;
`ifdef AER_TX_TIMEOUT_EN
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                        r_terr  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
`endif
                    end
                end
                S_ACKLO: begin
                    if (!aer.aer_ack) begin
                        r_state <= S_IDLE;
`ifdef AER_TX_TIMEOUT_EN
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        r_state <= S_IDLE;
                        r_terr  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign aer.aer_req  = r_req;
    assign aer.aer_addr = r_addr;
    assign aer.evt_lost = r_lost;
    assign aer.busy     = (r_state != S_IDLE);
`ifdef AER_TX_TIMEOUT_EN
    assign aer.timeout_err = r_terr;
`else
    assign aer.timeout_err = 1'b0;
`endif
endmodule
